instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encodes field-level instruction descriptors into 32-bit RV32I instruction words and streams them into instruction memory through a word-write port.
- Uses the same opcode set the core's control decoder consumes: R, I, L, S, B, JAL, JALR.
- Used as the test/boot program loader ahead of the single-cycle core.
- Descriptors arrive over a valid/ready handshake; one memory write per accepted descriptor.

Parameters:
ADDR_W, 8, imem word-address width
DEPTH, 256, maximum words written per load session (<= 2^ADDR_W)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begins a load session (honoured only in IDLE)
base_addr  in  ADDR_W  first word address, captured on start
in_valid  in  1  descriptor valid
in_ready  out  1  block can accept descriptor
in_fmt  in  3  0=R 1=I 2=S 3=L 4=B 5=JAL 6=JALR 7=illegal
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3 field
in_funct7  in  7  funct7 field (R only)
in_imm  in  21  signed immediate, byte offset for B/JAL
in_last  in  1  descriptor is final of session
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
busy  out  1  session active (RUN or DONE)
done  out  1  one-cycle pulse at session end
word_count  out  ADDR_W+1  words written this session
err_fmt  out  1  sticky: illegal fmt seen
err_full  out  1  sticky: DEPTH reached before in_last

Behaviour:
- Reset (async): state=IDLE; in_ready, imem_we, busy, done, err_fmt, err_full = 0; imem_addr, imem_wdata, word_count = 0. Asserting rst mid-session aborts immediately; no further writes occur.
- FSM states:
  - IDLE: in_ready=0. start -> RUN; capture base_addr; clear word_count and the sticky errors.
  - RUN: in_ready = (word_count < DEPTH). Transfer = in_valid & in_ready.
  - DONE: one cycle; done=1, then return to IDLE. start is ignored in RUN and DONE.
- Write latency: a transfer in cycle N produces imem_we=1 in cycle N+1, with imem_addr = base_addr + word_count (pre-increment, modulo 2^ADDR_W wrap) and the registered encoded word. word_count increments in cycle N+1. Throughput is one descriptor per cycle.
- Opcodes and field packing:
  - R, 0110011: {funct7, rs2, rs1, funct3, rd, op}.
  - I, 0010011 / L, 0000011: {imm[11:0], rs1, funct3, rd, op}.
  - S, 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B, 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - JAL, 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - JALR, 1100111: I layout with funct3 forced to 000.
  - Unused descriptor fields are ignored.
- Illegal fmt (7): the descriptor is accepted but not written (no imem_we, word_count unchanged); err_fmt is set.
- in_last transfer -> DONE in the following cycle, concurrent with the last write. An illegal last descriptor still ends the session.
- Full: when word_count reaches DEPTH without in_last, in_ready drops, err_full is set and the FSM enters DONE.
- busy=1 in RUN and DONE.

Optional Feature:
IMM_RANGE_CHECK_EN:
- When defined: output err_imm (sticky, cleared on start) is set if the immediate does not fit its format:
  - I/L/S/JALR: signed 12-bit.
  - B: signed 13-bit, even.
  - JAL: signed 21-bit, even.
  - The word is still written, with the imm truncated.
- When undefined: no check and no err_imm port; the immediate is silently truncated.

Test Plan:
- start with base_addr=0x10; send R add rd=3 rs1=1 rs2=2 f3=0 f7=0, in_last=1 -> one cycle later imem_we=1, addr=0x10, wdata=0x002081B3; done pulses next cycle; word_count=1.
- Back-to-back stream with in_valid held high: I addi rd=1 rs1=0 imm=5; S sw rs1=1 rs2=2 f3=2 imm=8; B beq imm=8; JAL rd=1 imm=16 (last) -> words 0x00500093, 0x0020A423, 0x00000463, 0x010000EF at consecutive addresses, one per cycle.
- fmt=7 between two valid descriptors -> only 2 writes, contiguous addresses, err_fmt=1, word_count=2.
- DEPTH=4, send 6 descriptors with no in_last -> 4 writes, in_ready low after the 4th, err_full=1, done pulses.
- Assert rst while in RUN with in_valid high -> all outputs 0 in the same cycle, no imem_we after; start is then accepted normally.
- With IMM_RANGE_CHECK_EN: addi imm=2048 -> err_imm=1, wdata imm field 0x800. B imm=3 -> err_imm=1.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instruction descriptors and streams them into instruction memory.
// Optional feature macro: IMM_RANGE_CHECK_EN adds a sticky err_imm immediate range flag.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [20:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_fmt,
    output logic              err_full
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic              err_imm
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0] count_next_c;
    logic [31:0]      enc_c;
    logic             legal_c;
    logic             xfer_c;
    logic             full_c;

    assign xfer_c = in_valid && in_ready;

    // Field packing per instruction format; fmt 7 has no encoding
    always_comb begin
        enc_c   = '0;
        legal_c = 1'b1;
        case (in_fmt)
            3'd0: enc_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            3'd1: enc_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            3'd2: enc_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
            3'd3: enc_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_L};
            3'd4: enc_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OP_B};
            3'd5: enc_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            3'd6: enc_c = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            default: legal_c = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic imm_bad_c;

    // Upper bits must be a pure sign extension; branch/jump offsets must be even
    always_comb begin
        imm_bad_c = 1'b0;
        case (in_fmt)
            3'd1, 3'd2, 3'd3, 3'd6:
                imm_bad_c = !((&in_imm[20:11]) || !(|in_imm[20:11]));
            3'd4: imm_bad_c = !((&in_imm[20:12]) || !(|in_imm[20:12])) || in_imm[0];
            3'd5: imm_bad_c = in_imm[0];
            default: imm_bad_c = 1'b0;
        endcase
    end
`else
    logic imm_lsb_unused;
    assign imm_lsb_unused = in_imm[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        full_c     = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN: begin
                if (xfer_c && in_last) begin
                    state_next = S_DONE;
                end else if (word_count >= DEPTH_CNT) begin
                    state_next = S_DONE;
                    full_c     = 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        count_next_c = word_count;
        if (state == S_IDLE && start)  count_next_c = '0;
        else if (xfer_c && legal_c)    count_next_c = word_count + CNT_W'(1);
    end

    // Write pipeline: address uses the pre-increment count of the accepted descriptor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            err_fmt    <= 1'b0;
            err_full   <= 1'b0;
            base       <= '0;
        end else begin
            in_ready   <= (state_next == S_RUN) && (count_next_c < DEPTH_CNT);
            imem_we    <= xfer_c && legal_c;
            busy       <= (state_next != S_IDLE);
            done       <= (state_next == S_DONE);
            word_count <= count_next_c;
            if (state == S_IDLE && start) begin
                base     <= base_addr;
                err_fmt  <= 1'b0;
                err_full <= 1'b0;
            end else begin
                if (xfer_c && legal_c) begin
                    imem_addr  <= base + word_count[ADDR_W-1:0];
                    imem_wdata <= enc_c;
                end
                if (xfer_c && !legal_c) err_fmt  <= 1'b1;
                if (full_c)             err_full <= 1'b1;
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         err_imm <= 1'b0;
        else if (state == S_IDLE && start) err_imm <= 1'b0;
        else if (xfer_c && imm_bad_c)    err_imm <= 1'b1;
    end
`endif

endmodule
